// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI serializer: FSM states, SPI mode and DC encoding.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Mode 0: sclk idles low, data launched in the low phase, sampled on the rise.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period tick generator: owns the sclk divider count and pulses o_tick on the
// last clk cycle of every CLK_DIV-cycle phase.
module sclk_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;

    assign o_tick = i_en && (r_div_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_div_cnt <= '0;
        else if (i_clr || o_tick)
            r_div_cnt <= '0;
        else if (i_en)
            r_div_cnt <= r_div_cnt + 1'b1;
    end

endmodule

// File: rtl/lcd_spi_serializer.sv
// SPI mode-0 word serializer for the LCD: ready/valid word intake, divided sclk,
// active-low CS held across back-to-back words, per-word DC and bit order.
module lcd_spi_serializer
    import lcd_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter int CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  valid,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic                  dc_in,
    input  logic                  lsb_first,
    output logic                  sclk,
    output logic                  sd,
    output logic                  dc,
    output logic                  cs_n,
    output logic                  busy
);

    localparam int BW = $clog2(WORD_WIDTH);
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t                r_state, w_state_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [BW-1:0]         r_bit_cnt, w_bit_nxt;
    logic [GW-1:0]         r_gap_cnt, w_gap_nxt;
    logic [WORD_WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic                  r_lsb, w_lsb_nxt;
    logic                  r_sclk, r_sd, r_dc, r_cs_n, r_busy;
    logic                  w_sclk_nxt, w_sd_nxt, w_dc_nxt, w_cs_n_nxt, w_busy_nxt;
    logic                  w_tick, w_shift_tick, w_last_bit, w_word_end, w_bit_adv;
    logic                  w_accept, w_last_gap;

    sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_en   ((r_state == SHIFT) || (r_state == HOLD)),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    assign w_shift_tick = (r_state == SHIFT) && w_tick;
    assign w_last_bit   = (r_bit_cnt == BW'(WORD_WIDTH - 1));
    assign w_word_end   = w_shift_tick && r_phase && w_last_bit;
    assign w_bit_adv    = w_shift_tick && r_phase && !w_last_bit;
    assign w_last_gap   = (r_gap_cnt == GW'(CS_GAP - 1));

    assign ready    = !rst && ((r_state == IDLE) || w_word_end);
    assign w_accept = valid && ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_phase   <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shreg   <= '0;
            r_lsb     <= 1'b0;
            r_sclk    <= SPI_CPOL;
            r_sd      <= 1'b0;
            r_dc      <= DC_CMD;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_shreg   <= w_shreg_nxt;
            r_lsb     <= w_lsb_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sd      <= w_sd_nxt;
            r_dc      <= w_dc_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_word_end && !valid) w_state_nxt = HOLD;
            HOLD:    if (w_tick) w_state_nxt = GAP;
            GAP:     if (w_last_gap) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of every registered output; accept has priority over bit advance.
    always_comb begin
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_lsb_nxt   = r_lsb;
        w_sd_nxt    = r_sd;
        w_dc_nxt    = r_dc;
        w_gap_nxt   = ((r_state == GAP) && !w_last_gap) ? r_gap_cnt + 1'b1 : '0;
        if (w_accept) begin
            w_phase_nxt = SPI_CPHA;
            w_bit_nxt   = '0;
            w_lsb_nxt   = lsb_first;
            w_dc_nxt    = dc_in;
            w_sd_nxt    = lsb_first ? data[0] : data[WORD_WIDTH-1];
            w_shreg_nxt = lsb_first ? (data >> 1) : (data << 1);
        end else begin
            if (w_shift_tick)
                w_phase_nxt = !r_phase;
            if (w_bit_adv) begin
                w_bit_nxt   = r_bit_cnt + 1'b1;
                w_sd_nxt    = r_lsb ? r_shreg[0] : r_shreg[WORD_WIDTH-1];
                w_shreg_nxt = r_lsb ? (r_shreg >> 1) : (r_shreg << 1);
            end
        end
        w_sclk_nxt = SPI_CPOL ^ ((w_state_nxt == SHIFT) && w_phase_nxt);
        w_cs_n_nxt = !((w_state_nxt == SHIFT) || (w_state_nxt == HOLD));
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign sclk = r_sclk;
    assign sd   = r_sd;
    assign dc   = r_dc;
    assign cs_n = r_cs_n;
    assign busy = r_busy;

endmodule

// File: tb/tb_lcd_spi_serializer.sv
// Directed bench for lcd_spi_serializer: scoreboard of words seen on sclk rises,
// plus cycle-accurate checks of framing, latency and reset behaviour.
module tb_lcd_spi_serializer;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready, valid, dc_in, lsb_first, sclk, sd, dc, cs_n, busy;
    logic [7:0]  data;
    logic        ready2, valid2, dc_in2, lsb2, sclk2, sd2, dc2, cs_n2, busy2;
    logic [15:0] data2;

    always #5 clk = ~clk;

    lcd_spi_serializer #(.WORD_WIDTH(8), .CLK_DIV(2), .CS_GAP(2)) dut (
        .clk(clk), .rst(rst), .ready(ready), .valid(valid), .data(data),
        .dc_in(dc_in), .lsb_first(lsb_first), .sclk(sclk), .sd(sd), .dc(dc),
        .cs_n(cs_n), .busy(busy)
    );

    lcd_spi_serializer #(.WORD_WIDTH(16), .CLK_DIV(1), .CS_GAP(2)) dut2 (
        .clk(clk), .rst(rst), .ready(ready2), .valid(valid2), .data(data2),
        .dc_in(dc_in2), .lsb_first(lsb2), .sclk(sclk2), .sd(sd2), .dc(dc2),
        .cs_n(cs_n2), .busy(busy2)
    );

    typedef struct packed {
        logic [7:0] bits;
        logic       dcv;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0, cyc = 0, hs = 0, acc_cyc = 0;
    int sink_words = 0, sclk_rises = 0, cs_rises = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Bits in the order they appear on the wire, first bit in the MSB position.
    function automatic logic [7:0] wire_order(input logic [7:0] d, input logic lsb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = lsb ? d[7-i] : d[i];
        return r;
    endfunction

    task automatic step();
        logic acc;
        exp_t e;
        acc = valid && ready;
        if (acc) begin
            e.bits = wire_order(data, lsb_first);
            e.dcv  = dc_in;
            exp_q.push_back(e);
            hs++;
        end
        @(posedge clk);
        #1;
        if (acc) acc_cyc = cyc;
    endtask

    task automatic send(input logic [7:0] d, input logic d_c, input logic l);
        valid = 1'b1; data = d; dc_in = d_c; lsb_first = l;
        for (int i = 0; i < 100; i++) begin
            if (ready) begin
                step();
                valid = 1'b0;
                return;
            end
            step();
        end
        chk("send_timeout", 32'(ready), 32'd1);
        valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy && ready) return;
            step();
        end
        chk("idle_timeout_busy", 32'(busy), 32'd0);
        chk("idle_timeout_ready", 32'(ready), 32'd1);
    endtask

    initial begin : sink
        logic [7:0] w;
        logic       wdc, sp, cp;
        int         bn;
        exp_t       e;
        w = '0; wdc = 1'b0; sp = 1'b0; cp = 1'b1; bn = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bn = 0;
            end else if (sclk && !sp) begin
                sclk_rises++;
                if (bn == 0) wdc = dc;
                w = {w[6:0], sd};
                bn++;
                if (bn == 8) begin
                    bn = 0;
                    sink_words++;
                    chk("sink_has_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("sink_word", 32'(w), 32'(e.bits));
                        chk("sink_dc", 32'(wdc), 32'(e.dcv));
                    end
                end
            end
            if (!rst && cs_n && !cp) cs_rises++;
            sp = sclk;
            cp = cs_n;
        end
    end

    initial begin : stim
        int a0, r0, s0, h0, w0;
        logic tog_ok, cs_ok, acc;
        logic [15:0] w2;

        rst = 1'b1; valid = 1'b0; data = '0; dc_in = 1'b0; lsb_first = 1'b0;
        valid2 = 1'b0; data2 = '0; dc_in2 = 1'b0; lsb2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sd", 32'(sd), 32'd0);
        chk("rst_dc", 32'(dc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready_forced_low", 32'(ready), 32'd0);
        chk("rst_cs_n2", 32'(cs_n2), 32'd1);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(ready), 32'd1);

        // 0xA5 MSB first: framing and latency
        send(8'hA5, DC_DATA, 1'b0);
        chk("t1_cs_low_first", 32'(cs_n), 32'd0);
        chk("t1_dc", 32'(dc), 32'(DC_DATA));
        chk("t1_sd_first", 32'(sd), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        cs_ok = 1'b1;
        for (int n = 0; n <= 36; n++) begin
            if (n <= 33 && cs_n !== 1'b0) cs_ok = 1'b0;
            if (n == 1) chk("t1_sclk_low", 32'(sclk), 32'd0);
            if (n == 2) chk("t1_sclk_first_rise", 32'(sclk), 32'd1);
            if (n == 34) chk("t1_cs_high", 32'(cs_n), 32'd1);
            if (n == 35) begin
                chk("t1_gap_ready", 32'(ready), 32'd0);
                chk("t1_gap_busy", 32'(busy), 32'd1);
            end
            if (n == 36) begin
                chk("t1_ready_again", 32'(ready), 32'd1);
                chk("t1_idle_busy", 32'(busy), 32'd0);
            end
            if (n < 36) step();
        end
        chk("t1_cs_low_span", 32'(cs_ok), 32'd1);

        // LSB first
        wait_idle();
        send(8'hA5, DC_CMD, 1'b1);
        chk("t2_sd_first", 32'(sd), 32'd1);
        wait_idle();
        send(8'h01, DC_CMD, 1'b1);
        wait_idle();
        send(8'h2C, DC_DATA, 1'b1);
        chk("t2_sd_first_2c", 32'(sd), 32'd0);
        wait_idle();

        // back-to-back words keep CS low
        send(8'h2C, DC_CMD, 1'b0);
        a0 = acc_cyc; r0 = cs_rises; s0 = sclk_rises;
        chk("t3_dc_first", 32'(dc), 32'(DC_CMD));
        send(8'hFF, DC_DATA, 1'b0);
        chk("t3_accept_spacing", 32'(acc_cyc - a0), 32'd32);
        chk("t3_dc_second", 32'(dc), 32'(DC_DATA));
        chk("t3_cs_still_low", 32'(cs_n), 32'd0);
        chk("t3_no_cs_rise_between", 32'(cs_rises - r0), 32'd0);
        wait_idle();
        chk("t3_one_cs_rise", 32'(cs_rises - r0), 32'd1);
        chk("t3_sclk_pulses", 32'(sclk_rises - s0), 32'd16);

        // async reset mid-word
        send(8'hE7, DC_DATA, 1'b0);
        repeat (10) step();
        chk("t4_pre_sclk", 32'(sclk), 32'd1);
        chk("t4_pre_sd", 32'(sd), 32'd1);
        rst = 1'b1;
        #1;
        chk("t4_rst_cs_n", 32'(cs_n), 32'd1);
        chk("t4_rst_sclk", 32'(sclk), 32'd0);
        chk("t4_rst_sd", 32'(sd), 32'd0);
        chk("t4_rst_dc", 32'(dc), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        s0 = sink_words;
        send(8'h3C, DC_CMD, 1'b0);
        wait_idle();
        chk("t4_word_after_reset", 32'(sink_words - s0), 32'd1);

        // 16-bit word at CLK_DIV=1
        valid2 = 1'b1; data2 = 16'h8001; dc_in2 = 1'b1; lsb2 = 1'b0;
        for (int i = 0; i < 10 && !ready2; i++) step();
        chk("t5_ready", 32'(ready2), 32'd1);
        step();
        valid2 = 1'b0;
        chk("t5_dc", 32'(dc2), 32'd1);
        tog_ok = 1'b1;
        w2 = '0;
        for (int n = 0; n <= 33; n++) begin
            if (n < 32 && sclk2 !== n[0]) tog_ok = 1'b0;
            if (n < 32 && n[0]) w2 = {w2[14:0], sd2};
            if (n == 31) chk("t5_cs_low_last", 32'(cs_n2), 32'd0);
            if (n == 32) chk("t5_hold_sclk", 32'(sclk2), 32'd0);
            if (n == 33) chk("t5_cs_high", 32'(cs_n2), 32'd1);
            step();
        end
        chk("t5_toggle", 32'(tog_ok), 32'd1);
        chk("t5_word", 32'(w2), 32'h8001);

        // valid toggling in every state
        wait_idle();
        h0 = hs; w0 = sink_words;
        data = 8'($urandom); dc_in = 1'($urandom); lsb_first = 1'($urandom);
        for (int i = 0; i < 300; i++) begin
            acc = valid && ready;
            step();
            if (acc) begin
                data = 8'($urandom); dc_in = 1'($urandom); lsb_first = 1'($urandom);
            end
            valid = ($urandom_range(0, 2) == 0);
        end
        valid = 1'b0;
        wait_idle();
        chk("t6_some_handshakes", 32'((hs - h0) > 0), 32'd1);
        chk("t6_words_eq_handshakes", 32'(sink_words - w0), 32'(hs - h0));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
